// File: rtl/rv32_types.sv
// Shared rv32 types: branch op encoding, BHT counter type and
// its reset/saturation constants, plus the counter-step helper.
package rv32_types;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_J    = 3'b010,
    OP_NONE = 3'b011,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } branch_op_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET_VAL = 2'b01;
  localparam bht_ctr_t BHT_MAX       = 2'b11;

  // 2-bit saturating step toward the observed outcome
  function automatic bht_ctr_t bht_next(
    input bht_ctr_t c,
    input logic     t
  );
    if (t)
      return (c == BHT_MAX) ? c : c + 2'd1;
    else
      return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/rv32_branch_predict_unit_if.sv
// Predict/resolve bus of the branch predict unit.
// master = pipeline side, slave = predict unit side.
interface rv32_branch_predict_unit_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  import rv32_types::*;

  logic [XLEN-1:0]   pred_pc;
  logic              pred_taken;
  logic              res_valid_in;
  logic              res_flush;
  logic [XLEN-1:0]   op1;
  logic [XLEN-1:0]   op2;
  branch_op_t        branch_op;
  logic [XLEN-1:0]   res_pc;
  logic [XLEN-1:0]   res_target;
  logic              res_pred_taken;
  logic              res_valid;
  logic              do_branch;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [STAT_W-1:0] stat_resolved;
  logic [STAT_W-1:0] stat_mispredict;

  modport master (
    output pred_pc, res_valid_in, res_flush,
    output op1, op2, branch_op,
    output res_pc, res_target, res_pred_taken,
    input  pred_taken, res_valid, do_branch,
    input  mispredict, redirect_pc,
    input  stat_resolved, stat_mispredict
  );

  modport slave (
    input  pred_pc, res_valid_in, res_flush,
    input  op1, op2, branch_op,
    input  res_pc, res_target, res_pred_taken,
    output pred_taken, res_valid, do_branch,
    output mispredict, redirect_pc,
    output stat_resolved, stat_mispredict
  );

endinterface

// File: rtl/rv32_branch_cond.sv
// Branch condition evaluation: op1/op2/branch_op in,
// taken / is_cond (conditional branch) / is_branch out.
module rv32_branch_cond
  import rv32_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  branch_op_t      branch_op,
  output logic            taken,
  output logic            is_cond,
  output logic            is_branch
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (op1 == op2);
  assign lt  = ($signed(op1) < $signed(op2));
  assign ltu = (op1 < op2);

  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    unique case (1'b1)
      (branch_op == OP_BEQ):  begin taken = eq;   is_cond = 1'b1; end
      (branch_op == OP_BNE):  begin taken = !eq;  is_cond = 1'b1; end
      (branch_op == OP_BLT):  begin taken = lt;   is_cond = 1'b1; end
      (branch_op == OP_BGE):  begin taken = !lt;  is_cond = 1'b1; end
      (branch_op == OP_BLTU): begin taken = ltu;  is_cond = 1'b1; end
      (branch_op == OP_BGEU): begin taken = !ltu; is_cond = 1'b1; end
      (branch_op == OP_J):    taken = 1'b1;
      default: ;
    endcase
  end

  assign is_branch = is_cond | (branch_op == OP_J);

endmodule

// File: rtl/rv32_branch_predict_unit.sv
// Branch resolve + BHT predictor: combinational pred_taken from a
// 2-bit counter table, registered resolve result, saturating stats.
module rv32_branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  rv32_branch_predict_unit_if.slave bus
);
  import rv32_types::*;

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_ctr_t bht [BHT_ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             taken;
  logic             is_cond;
  logic             is_branch;
  logic             accept;
  logic             mis_next;
  logic [XLEN-1:0]  redir_next;

  logic              valid_q;
  logic              taken_q;
  logic              mis_q;
  logic [XLEN-1:0]   redir_q;
  logic [STAT_W-1:0] res_cnt;
  logic [STAT_W-1:0] mis_cnt;

  logic pc_unused;
  assign pc_unused = ^{bus.pred_pc[XLEN-1:IDX_W+2],
                       bus.pred_pc[1:0]};

  assign pred_idx = bus.pred_pc[IDX_W+1:2];
  assign res_idx  = bus.res_pc[IDX_W+1:2];

  rv32_branch_cond #(.XLEN(XLEN)) u_cond (
    .op1       (bus.op1),
    .op2       (bus.op2),
    .branch_op (bus.branch_op),
    .taken     (taken),
    .is_cond   (is_cond),
    .is_branch (is_branch)
  );

  assign accept   = bus.res_valid_in & ~bus.res_flush & is_branch;
  assign mis_next = taken ^ bus.res_pred_taken;
  assign redir_next = taken ? bus.res_target
                            : bus.res_pc + XLEN'(4);

  // Read is the pre-update value: no same-cycle bypass
  assign bus.pred_taken = bht[pred_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= BHT_RESET_VAL;
    end else if (accept && is_cond) begin
      bht[res_idx] <= bht_next(bht[res_idx], taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
      redir_q <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        taken_q <= taken;
        mis_q   <= mis_next;
        redir_q <= redir_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
      mis_cnt <= '0;
    end else if (accept) begin
      if (!(&res_cnt))
        res_cnt <= res_cnt + STAT_W'(1);
      if (mis_next && !(&mis_cnt))
        mis_cnt <= mis_cnt + STAT_W'(1);
    end
  end

  assign bus.res_valid       = valid_q;
  assign bus.do_branch       = taken_q;
  assign bus.mispredict      = valid_q & mis_q;
  assign bus.redirect_pc     = redir_q;
  assign bus.stat_resolved   = res_cnt;
  assign bus.stat_mispredict = mis_cnt;

endmodule

// File: tb/tb_rv32_branch_predict_unit.sv
// Self-checking bench for rv32_branch_predict_unit: compare table,
// directed training/flush/reset sequences and random vs. model.
module tb_rv32_branch_predict_unit;
  import rv32_types::*;

  localparam int SW = 4;
  localparam int SMAX = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv32_branch_predict_unit_if #(.XLEN(32), .STAT_W(SW)) bus ();

  rv32_branch_predict_unit #(
    .XLEN(32), .BHT_ENTRIES(64), .STAT_W(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  // reference model state
  int          m_bht [64];
  int          m_res;
  int          m_mis;
  logic        m_valid;
  logic        m_do;
  logic        m_misb;
  logic [31:0] m_redir;

  typedef struct {
    branch_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  vec_t tbl [10];

  function automatic logic ref_taken(branch_op_t op,
                                     logic [31:0] a, logic [31:0] b);
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return $signed(a) < $signed(b);
      OP_BGE:  return !($signed(a) < $signed(b));
      OP_BLTU: return a < b;
      OP_BGEU: return !(a < b);
      OP_J:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_res = 0; m_mis = 0;
    m_valid = 0; m_do = 0; m_misb = 0; m_redir = 0;
  endtask

  task automatic idle_inputs();
    bus.res_valid_in   = 0;
    bus.res_flush      = 0;
    bus.op1            = 0;
    bus.op2            = 0;
    bus.branch_op      = OP_NONE;
    bus.res_pc         = 0;
    bus.res_target     = 0;
    bus.res_pred_taken = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_do"}, 32'(bus.do_branch), 0);
    chk({tag, "_mis"}, 32'(bus.mispredict), 0);
    chk({tag, "_redir"}, bus.redirect_pc, 0);
    chk({tag, "_sres"}, 32'(bus.stat_resolved), 0);
    chk({tag, "_smis"}, 32'(bus.stat_mispredict), 0);
  endtask

  // rst rises between edges; outputs must clear without a clock edge
  task automatic do_reset(input string tag);
    rst = 1;
    #3;
    check_zero(tag);
    @(negedge clk);
    rst = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive at posedge+1, check prediction, then check
  // the registered result at the following posedge+1.
  task automatic cycle(input logic v, input logic fl,
                       input branch_op_t op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] pp);
    logic acc;
    logic tk;
    int   idx;
    bus.res_valid_in   = v;
    bus.res_flush      = fl;
    bus.branch_op      = op;
    bus.op1            = a;
    bus.op2            = b;
    bus.res_pc         = pc;
    bus.res_target     = tgt;
    bus.res_pred_taken = pt;
    bus.pred_pc        = pp;
    #1;
    chk("pred_taken", 32'(bus.pred_taken),
        32'(m_bht[int'(pp[7:2])] >= 2));
    tk  = ref_taken(op, a, b);
    acc = v && !fl && (op != OP_NONE);
    idx = int'(pc[7:2]);
    @(posedge clk);
    #1;
    m_valid = acc;
    if (acc) begin
      m_do    = tk;
      m_misb  = (tk != pt);
      m_redir = tk ? tgt : pc + 32'd4;
      m_res   = (m_res < SMAX) ? m_res + 1 : SMAX;
      if (m_misb) m_mis = (m_mis < SMAX) ? m_mis + 1 : SMAX;
      if (op != OP_J) begin
        if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
        else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
      end
    end
    idle_inputs();
    chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
    chk("do_branch", 32'(bus.do_branch), 32'(m_do));
    chk("redirect_pc", bus.redirect_pc, m_redir);
    if (m_valid) chk("mispredict", 32'(bus.mispredict), 32'(m_misb));
    chk("stat_resolved", 32'(bus.stat_resolved), 32'(m_res));
    chk("stat_mispredict", 32'(bus.stat_mispredict), 32'(m_mis));
  endtask

  logic [31:0] a, b, pc, pp;
  logic        pt;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1;
    bus.pred_pc = 0;
    idle_inputs();
    model_reset();

    tbl[0] = '{OP_BLT,  32'hFFFF_FFFF, 32'd1, 1'b1};
    tbl[1] = '{OP_BLTU, 32'hFFFF_FFFF, 32'd1, 1'b0};
    tbl[2] = '{OP_BGE,  32'hFFFF_FFFF, 32'd1, 1'b0};
    tbl[3] = '{OP_BGEU, 32'hFFFF_FFFF, 32'd1, 1'b1};
    tbl[4] = '{OP_BEQ,  32'd5, 32'd5, 1'b1};
    tbl[5] = '{OP_BNE,  32'd5, 32'd5, 1'b0};
    tbl[6] = '{OP_J,    32'd0, 32'd9, 1'b1};
    tbl[7] = '{OP_BLT,  32'd1, 32'hFFFF_FFFF, 1'b0};
    tbl[8] = '{OP_BGE,  32'd7, 32'd7, 1'b1};
    tbl[9] = '{OP_BLTU, 32'd0, 32'd1, 1'b1};

    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // compare table; an idle cycle after each shows the 1-cycle pulse
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, tbl[i].op, tbl[i].a, tbl[i].b,
            32'h40 + 32'(i * 4), 32'h800, 0, 0);
      chk($sformatf("tbl%0d_do", i), 32'(bus.do_branch),
          32'(tbl[i].exp));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.res_valid), 1);
      cycle(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
      chk($sformatf("tbl%0d_pulse", i), 32'(bus.res_valid), 0);
    end

    // training at 0x100
    do_reset("rst_train");
    for (int i = 0; i < 4; i++) begin
      pt = (m_bht[0] >= 2);
      chk($sformatf("train%0d_pred", i), 32'(pt),
          32'(i != 0));
      cycle(1, 0, OP_BEQ, 3, 3, 32'h100, 32'h2000, pt, 32'h100);
      chk($sformatf("train%0d_mis", i), 32'(bus.mispredict),
          32'(i == 0));
      chk($sformatf("train%0d_redir", i), bus.redirect_pc, 32'h2000);
    end
    cycle(1, 0, OP_BEQ, 3, 4, 32'h100, 32'h2000, 1, 32'h100);
    chk("nt_redir", bus.redirect_pc, 32'h104);
    bus.pred_pc = 32'h100;
    #1;
    chk("sat_still_taken", 32'(bus.pred_taken), 1);
    bus.pred_pc = 32'h200;
    #1;
    chk("alias_0x200", 32'(bus.pred_taken), 1);
    #1;

    // not-taken redirect wraps
    cycle(1, 0, OP_BNE, 5, 5, 32'hFFFF_FFFC, 32'h10, 1, 0);
    chk("wrap_mis", 32'(bus.mispredict), 1);
    chk("wrap_redir", bus.redirect_pc, 32'h0);

    // flush and non-branch leave state alone
    cycle(1, 1, OP_BEQ, 1, 1, 32'h100, 32'h300, 0, 32'h100);
    chk("flush_valid", 32'(bus.res_valid), 0);
    cycle(1, 0, OP_NONE, 1, 1, 32'h100, 32'h300, 0, 32'h100);
    chk("nonbr_valid", 32'(bus.res_valid), 0);

    // simultaneous predict/update and back-to-back at index 5
    do_reset("rst_simul");
    cycle(1, 0, OP_BEQ, 0, 0, 32'h14, 32'h80, 0, 32'h14);
    cycle(1, 0, OP_BEQ, 0, 0, 32'h114, 32'h80, 1, 32'h14);
    chk("b2b_mis", 32'(bus.mispredict), 0);

    // reset mid-stream while a result is valid
    cycle(1, 0, OP_J, 0, 0, 32'h20, 32'h4444, 0, 0);
    chk("mid_valid", 32'(bus.res_valid), 1);
    do_reset("rst_mid");
    bus.pred_pc = 32'h14;
    #1;
    chk("post_rst_pred", 32'(bus.pred_taken), 0);
    cycle(1, 0, OP_BEQ, 0, 0, 32'h14, 32'h80, 0, 32'h14);
    bus.pred_pc = 32'h14;
    #1;
    chk("post_rst_weak", 32'(bus.pred_taken), 1);
    #1;

    // stat saturation at 15
    for (int i = 0; i < 20; i++)
      cycle(1, 0, OP_J, 0, 0, 32'h30, 32'h90, 0, 0);
    chk("sat_res", 32'(bus.stat_resolved), 15);
    chk("sat_mis", 32'(bus.stat_mispredict), 15);

    // random traffic against the model
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
      pc = {$urandom_range(0, 1) ? 32'hFFFF_FF00 : 32'h0}
           | 32'($urandom_range(0, 255));
      pp = 32'($urandom_range(0, 1023));
      pt = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0),
            branch_op_t'($urandom_range(0, 7)),
            a, b, pc, $urandom, pt, pp);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
